// File: rtl/bus_pkg.sv
// Shared data-bus types: transfer size, request/response bundles, and the
// request legality check used by memory-side responders.
package bus_pkg;

    typedef enum logic [1:0] {
        MSIZE1 = 2'd0,
        MSIZE2 = 2'd1,
        MSIZE4 = 2'd2
    } msize_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        msize_t      size;
        logic [3:0]  strobe;
        logic [31:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
        logic        err;
    } dbus_resp_t;

    // A request is rejected when it falls outside the 2^addr_bits-word array,
    // is misaligned for its size, or carries the reserved size encoding.
    function automatic logic dbus_req_err(input logic [31:0] addr,
                                          input logic [1:0]  size,
                                          input int unsigned addr_bits);
        logic err;
        err = ((addr >> (addr_bits + 2)) != 32'd0);
        if (size == 2'd1 && addr[0]) begin
            err = 1'b1;
        end
        if (size == 2'd2 && addr[1:0] != 2'b00) begin
            err = 1'b1;
        end
        if (size == 2'd3) begin
            err = 1'b1;
        end
        return err;
    endfunction

endpackage

// File: rtl/sram_word_array.sv
// Single-port 32-bit word SRAM with per-byte write enables and a registered
// read port (read-before-write). No reset so it maps onto block RAM.
module sram_word_array #(
    parameter int ADDR_BITS = 12
) (
    input  logic                 clk,
    input  logic                 en,
    input  logic [3:0]           we,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [31:0]          wdata,
    output logic [31:0]          rdata
);

    logic [31:0] mem [0:(1 << ADDR_BITS) - 1];

    // Byte-lane writes and registered read on every enabled cycle.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < 4; i++) begin
                if (we[i]) begin
                    mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/dbus_sram_responder.sv
// Slave end of the CPU data-bus request/data_ok handshake backed by an
// on-chip word SRAM. One outstanding request; completion after LATENCY cycles.
module dbus_sram_responder
    import bus_pkg::*;
#(
    parameter int ADDR_BITS = 12,
    parameter int LATENCY   = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic [3:0]  req_strobe,
    input  logic [31:0] req_data,
    output logic        resp_addr_ok,
    output logic        resp_data_ok,
    output logic [31:0] resp_data,
    output logic        resp_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t     state, state_n;
    logic [3:0] cnt, cnt_n;
    logic       accept, access;

    dbus_req_t  req_in;
    dbus_req_t  req_p1;
    dbus_req_t  acc_req;
    dbus_resp_t resp;
    logic       acc_err;
    logic       err_p2;
    logic       rd_p2;

    logic                 mem_en;
    logic [31:0]          mem_rdata;
    logic [ADDR_BITS-1:0] mem_addr;

    assign req_in = '{valid:  req_valid,
                      addr:   req_addr,
                      size:   msize_t'(req_size),
                      strobe: req_strobe,
                      data:   req_data};

    // In IDLE the access (LATENCY==1 case) must use the live request, since
    // the latch only captures it at the same edge; otherwise use the latch.
    assign acc_req  = (state == S_IDLE) ? req_in : req_p1;
    assign acc_err  = dbus_req_err(acc_req.addr, acc_req.size, ADDR_BITS);
    assign mem_en   = access & ~acc_err;
    assign mem_addr = acc_req.addr[ADDR_BITS+1:2];

    sram_word_array #(
        .ADDR_BITS(ADDR_BITS)
    ) u_sram (
        .clk   (clk),
        .en    (mem_en),
        .we    (acc_req.strobe),
        .addr  (mem_addr),
        .wdata (acc_req.data),
        .rdata (mem_rdata)
    );

    // State and latency counter register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Next state, accept and access strobes. Accept/access are qualified by
    // resetn so nothing is accepted or written while reset is held.
    // cnt is loaded with LATENCY-1 and the access fires on the edge that
    // takes it to zero, giving data_ok exactly LATENCY cycles after accept.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        accept  = 1'b0;
        access  = 1'b0;
        case (state)
            S_IDLE: begin
                if (acc_req.valid && resetn) begin
                    accept = 1'b1;
                    cnt_n  = 4'(LATENCY - 1);
                    if (LATENCY > 1) begin
                        state_n = S_WAIT;
                    end else begin
                        access  = 1'b1;
                        state_n = S_RESP;
                    end
                end
            end
            S_WAIT: begin
                cnt_n = cnt - 4'd1;
                if (cnt <= 4'd1 && resetn) begin
                    access  = 1'b1;
                    state_n = S_RESP;
                end
            end
            S_RESP: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // Request latch, captured at the accept edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            req_p1 <= '0;
        end else if (accept) begin
            req_p1 <= req_in;
        end
    end

    // Completion flags, captured at the access edge alongside the SRAM read.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            err_p2 <= 1'b0;
            rd_p2  <= 1'b0;
        end else if (access) begin
            err_p2 <= acc_err;
            rd_p2  <= (acc_req.strobe == 4'b0000);
        end
    end

    // Response bundle: data and err are forced to zero outside the RESP cycle.
    always_comb begin
        resp         = '0;
        resp.addr_ok = accept;
        resp.data_ok = (state == S_RESP);
        resp.err     = (state == S_RESP) & err_p2;
        if (state == S_RESP && !err_p2 && rd_p2) begin
            resp.data = mem_rdata;
        end
    end

    assign resp_addr_ok = resp.addr_ok;
    assign resp_data_ok = resp.data_ok;
    assign resp_data    = resp.data;
    assign resp_err     = resp.err;

endmodule
